// File: rtl/spi_byte_master_pkg.sv
// Shared types and width helpers for the SPI word master and its clock generator.
package spi_byte_master_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Counter width able to hold values 0..range_v-1, never narrower than one bit.
  function automatic int cnt_width(input int range_v);
    return (range_v <= 2) ? 1 : $clog2(range_v);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period counter producing SCK and single-cycle leading/trailing edge strobes.
module spi_clkgen
  import spi_byte_master_pkg::*;
#(
  parameter int CPOL    = 0,
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_sck,
  output logic o_lead,
  output logic o_trail
);

  localparam int               DIV_W    = cnt_width(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic             SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0] r_cnt;
  logic             r_sck;
  logic             w_tick;

  // Strobes describe the toggle that SCK takes on this clock edge.
  assign w_tick  = i_run && (r_cnt == DIV_LAST);
  assign o_lead  = w_tick && (r_sck == SCK_IDLE);
  assign o_trail = w_tick && (r_sck != SCK_IDLE);
  assign o_sck   = r_sck;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_sck <= SCK_IDLE;
    end else if (!i_run) begin
      r_cnt <= '0;
      r_sck <= SCK_IDLE;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// SPI master streaming N-bit words MSB first with a word-level request/write/ack handshake.
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int N        = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int CLK_DIV  = 1,
  parameter int PREFETCH = 2
) (
  input  logic         sclk_i,
  input  logic         rst_i,
  output logic         spi_ssel_o,
  output logic         spi_sck_o,
  output logic         spi_mosi_o,
  input  logic         spi_miso_i,
  output logic         di_req_o,
  input  logic [N-1:0] di_i,
  input  logic         wren_i,
  output logic         wr_ack_o,
  output logic         do_valid_o,
  output logic [N-1:0] do_o
);

  localparam int               BIT_W         = cnt_width(N);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(N - 1);
  localparam logic [BIT_W-1:0] BIT_ONE       = BIT_W'(1);
  localparam logic [BIT_W-1:0] REQ_PREV      = BIT_W'(N - PREFETCH - 1);
  localparam bit               SHIFT_ON_LEAD = (CPHA != 0);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_tx;
  logic [N-1:0] r_rx;
  logic [N-1:0] r_do;
  logic [BIT_W-1:0] r_bit;
  logic         r_ssel;
  logic         r_mosi;
  logic         r_di_req;
  logic         r_wr_ack;
  logic         r_do_valid;
  logic         w_run;
  logic         w_lead;
  logic         w_trail;
  logic         w_boundary;
  logic         w_load;
  logic         w_stop;
  logic [N-1:0] w_rx_next;

  assign w_run      = (r_state == XFER);
  assign w_rx_next  = {r_rx[N-2:0], spi_miso_i};
  assign w_boundary = w_run && w_trail && (r_bit == BIT_LAST);

  spi_clkgen #(
    .CPOL    (CPOL),
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .i_clk   (sclk_i),
    .i_rst   (rst_i),
    .i_run   (w_run),
    .o_sck   (spi_sck_o),
    .o_lead  (w_lead),
    .o_trail (w_trail)
  );

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (wren_i) w_state_next = XFER;
        else        w_state_next = IDLE;
      end
      XFER: begin
        if (w_boundary && !wren_i) w_state_next = IDLE;
        else                       w_state_next = XFER;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A word is only ever accepted from IDLE or exactly at a word boundary.
  always_comb begin
    w_load = 1'b0;
    w_stop = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = wren_i;
        w_stop = 1'b0;
      end
      XFER: begin
        w_load = w_boundary && wren_i;
        w_stop = w_boundary && !wren_i;
      end
      default: begin
        w_load = 1'b0;
        w_stop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_do       <= '0;
      r_bit      <= '0;
      r_ssel     <= 1'b1;
      r_mosi     <= 1'b0;
      r_di_req   <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_do_valid <= 1'b0;
    end else begin
      r_wr_ack   <= w_load;
      r_do_valid <= w_boundary;
      // With CPHA=1 the last bit is sampled on this very edge, so take it from MISO directly.
      if (w_boundary) begin
        r_do <= SHIFT_ON_LEAD ? w_rx_next : r_rx;
      end
      if (w_load) begin
        r_tx     <= SHIFT_ON_LEAD ? di_i : {di_i[N-2:0], 1'b0};
        r_mosi   <= di_i[N-1];
        r_ssel   <= 1'b0;
        r_bit    <= '0;
        r_di_req <= 1'b0;
      end else if (w_stop || !w_run) begin
        r_mosi   <= 1'b0;
        r_ssel   <= 1'b1;
        r_di_req <= 1'b1;
      end else begin
        if (w_lead) begin
          if (SHIFT_ON_LEAD) begin
            r_mosi <= r_tx[N-1];
            r_tx   <= {r_tx[N-2:0], 1'b0};
          end else begin
            r_rx <= w_rx_next;
          end
        end
        if (w_trail) begin
          r_bit <= r_bit + BIT_ONE;
          if (r_bit == REQ_PREV) begin
            r_di_req <= 1'b1;
          end
          if (SHIFT_ON_LEAD) begin
            r_rx <= w_rx_next;
          end else begin
            r_mosi <= r_tx[N-1];
            r_tx   <= {r_tx[N-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi_ssel_o = r_ssel;
  assign spi_mosi_o = r_mosi;
  assign di_req_o   = r_di_req;
  assign wr_ack_o   = r_wr_ack;
  assign do_valid_o = r_do_valid;
  assign do_o       = r_do;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: a CPHA=0/CLK_DIV=1 instance and a CPHA=1/CLK_DIV=3 instance.
module tb_spi_byte_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: defaults.
  logic       rst0 = 1'b1, wren0 = 1'b0;
  logic [7:0] di0 = 8'h00;
  int         miso_mode0 = 0;
  logic       miso0, ssel0, sck0, mosi0, req0, ack0, dv0;
  logic [7:0] do0;
  assign miso0 = (miso_mode0 == 0) ? mosi0 : (miso_mode0 == 1);

  spi_byte_master #(.N(8), .CPOL(0), .CPHA(0), .CLK_DIV(1), .PREFETCH(2)) dut0 (
    .sclk_i(clk), .rst_i(rst0), .spi_ssel_o(ssel0), .spi_sck_o(sck0), .spi_mosi_o(mosi0),
    .spi_miso_i(miso0), .di_req_o(req0), .di_i(di0), .wren_i(wren0), .wr_ack_o(ack0),
    .do_valid_o(dv0), .do_o(do0));

  // Instance 1: CPHA=1, CLK_DIV=3, MISO looped back.
  logic       rst1 = 1'b1, wren1 = 1'b0;
  logic [7:0] di1 = 8'h00;
  logic       ssel1, sck1, mosi1, req1, ack1, dv1;
  logic [7:0] do1;

  spi_byte_master #(.N(8), .CPOL(0), .CPHA(1), .CLK_DIV(3), .PREFETCH(2)) dut1 (
    .sclk_i(clk), .rst_i(rst1), .spi_ssel_o(ssel1), .spi_sck_o(sck1), .spi_mosi_o(mosi1),
    .spi_miso_i(mosi1), .di_req_o(req1), .di_i(di1), .wren_i(wren1), .wr_ack_o(ack1),
    .do_valid_o(dv1), .do_o(do1));

  // Event recorders: what a slave sees on the wire plus handshake timestamps.
  logic p_sck0 = 1'b0, p_req0 = 1'b0, p_ssel0 = 1'b1;
  bit         mbits0[$];
  int         ack_cyc0[$], dv_cyc0[$], req_cyc0[$];
  logic [7:0] dv_val0[$];
  int         rise_n0 = 0, ssel_up0 = 0, idle_mosi0 = 0;

  always @(negedge clk) begin
    p_sck0  <= sck0;
    p_req0  <= req0;
    p_ssel0 <= ssel0;
    if (sck0 && !p_sck0) begin
      rise_n0 <= rise_n0 + 1;
      mbits0.push_back(mosi0);
    end
    if (ack0) ack_cyc0.push_back(cyc);
    if (dv0) begin
      dv_cyc0.push_back(cyc);
      dv_val0.push_back(do0);
    end
    if (req0 && !p_req0) req_cyc0.push_back(cyc);
    if (ssel0 && !p_ssel0) ssel_up0 <= ssel_up0 + 1;
    if (ssel0 && mosi0) idle_mosi0 <= idle_mosi0 + 1;
  end

  logic p_sck1 = 1'b0, p_mosi1 = 1'b0, p_ssel1 = 1'b1;
  bit         mbits1[$];
  int         ack_cyc1[$], dv_cyc1[$], rise_cyc1[$], fall_cyc1[$];
  logic [7:0] dv_val1[$];
  int         idle_mosi1 = 0, bad_mchg1 = 0;

  always @(negedge clk) begin
    p_sck1  <= sck1;
    p_mosi1 <= mosi1;
    p_ssel1 <= ssel1;
    if (sck1 && !p_sck1) rise_cyc1.push_back(cyc);
    if (!sck1 && p_sck1) begin
      fall_cyc1.push_back(cyc);
      mbits1.push_back(p_mosi1);
    end
    if (ack1) ack_cyc1.push_back(cyc);
    if (dv1) begin
      dv_cyc1.push_back(cyc);
      dv_val1.push_back(do1);
    end
    if (ssel1 && mosi1) idle_mosi1 <= idle_mosi1 + 1;
    if ((mosi1 != p_mosi1) && !ssel1 && !p_ssel1 && !(sck1 && !p_sck1)) bad_mchg1 <= bad_mchg1 + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated word on instance 0; expected RX word supplied by the caller.
  task automatic word0(input logic [7:0] w, input logic [7:0] exp_rx, input string tag);
    int na = ack_cyc0.size();
    int nd = dv_val0.size();
    int nb = mbits0.size();
    int k = 0;
    logic [7:0] got = 8'h00;
    while (!req0 && k < 100) begin step(); k++; end
    di0 = w;
    wren0 = 1'b1;
    step();
    wren0 = 1'b0;
    di0 = 8'($urandom);
    k = 0;
    while (dv_val0.size() == nd && k < 400) begin step(); k++; end
    check({tag, "_dv_count"}, 32'(dv_val0.size()), 32'(nd + 1));
    check({tag, "_ack_count"}, 32'(ack_cyc0.size()), 32'(na + 1));
    if (dv_val0.size() > nd && ack_cyc0.size() > na && mbits0.size() >= nb + 8) begin
      check({tag, "_do"}, 32'(dv_val0[nd]), 32'(exp_rx));
      check({tag, "_latency"}, 32'(dv_cyc0[nd] - ack_cyc0[na]), 32'd16);
      for (int i = 0; i < 8; i++) got = {got[6:0], mbits0[nb + i]};
      check({tag, "_mosi"}, 32'(got), 32'(w));
    end
    step();
    step();
    check({tag, "_ssel_after"}, 32'(ssel0), 32'd1);
    check({tag, "_do_hold"}, 32'(do0), 32'(exp_rx));
  endtask

  // One isolated loopback word on instance 1 (half-period 3 cycles).
  task automatic word1(input logic [7:0] w, input string tag);
    int na = ack_cyc1.size();
    int nd = dv_val1.size();
    int nb = mbits1.size();
    int nr = rise_cyc1.size();
    int nf = fall_cyc1.size();
    int k = 0;
    logic [7:0] got = 8'h00;
    while (!req1 && k < 100) begin step(); k++; end
    di1 = w;
    wren1 = 1'b1;
    step();
    wren1 = 1'b0;
    di1 = 8'($urandom);
    k = 0;
    while (dv_val1.size() == nd && k < 600) begin step(); k++; end
    check({tag, "_dv_count"}, 32'(dv_val1.size()), 32'(nd + 1));
    check({tag, "_rise_count"}, 32'(rise_cyc1.size() - nr), 32'd8);
    if (dv_val1.size() > nd && ack_cyc1.size() > na && mbits1.size() >= nb + 8 &&
        rise_cyc1.size() > nr && fall_cyc1.size() > nf) begin
      check({tag, "_do"}, 32'(dv_val1[nd]), 32'(w));
      check({tag, "_latency"}, 32'(dv_cyc1[nd] - ack_cyc1[na]), 32'd48);
      check({tag, "_first_rise"}, 32'(rise_cyc1[nr] - ack_cyc1[na]), 32'd3);
      check({tag, "_half_period"}, 32'(fall_cyc1[nf] - rise_cyc1[nr]), 32'd3);
      for (int i = 0; i < 8; i++) got = {got[6:0], mbits1[nb + i]};
      check({tag, "_mosi"}, 32'(got), 32'(w));
    end
  endtask

  initial begin
    int na, nd, nb, nr, su, rn, k;
    logic [7:0] got;
    logic [7:0] words [4];
    logic [7:0] rw;

    // Reset state and idle behaviour.
    step();
    step();
    check("rst_ssel", 32'(ssel0), 32'd1);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    check("rst_req", 32'(req0), 32'd0);
    check("rst_do", 32'(do0), 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    check("req_before_edge", 32'(req0), 32'd0);
    step();
    check("req_after_release", 32'(req0), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check("idle_no_ack", 32'(ack_cyc0.size()), 32'd0);
    check("idle_no_dv", 32'(dv_val0.size()), 32'd0);
    check("idle_ssel", 32'(ssel0), 32'd1);
    check("idle_sck", 32'(sck0), 32'd0);
    check("idle_req_rises", 32'(req_cyc0.size()), 32'd1);

    // Single loopback word.
    word0(8'hA5, 8'hA5, "single_a5");

    // Streaming four words with wren held high.
    words[0] = 8'h89; words[1] = 8'h81; words[2] = 8'h01; words[3] = 8'h00;
    na = ack_cyc0.size(); nd = dv_val0.size(); nb = mbits0.size();
    nr = req_cyc0.size(); su = ssel_up0; rn = rise_n0;
    for (int w = 0; w < 4; w++) begin
      k = 0;
      while (!req0 && k < 100) begin step(); k++; end
      di0 = words[w];
      wren0 = 1'b1;
      k = 0;
      do begin step(); k++; end while (!ack0 && k < 100);
      if (w == 3) wren0 = 1'b0;
    end
    wren0 = 1'b0;
    k = 0;
    while (dv_val0.size() < nd + 4 && k < 400) begin step(); k++; end
    step();
    step();
    check("stream_acks", 32'(ack_cyc0.size() - na), 32'd4);
    check("stream_dvs", 32'(dv_val0.size() - nd), 32'd4);
    check("stream_sck_pulses", 32'(rise_n0 - rn), 32'd32);
    check("stream_ssel_deassert", 32'(ssel_up0 - su), 32'd1);
    check("stream_ssel_end", 32'(ssel0), 32'd1);
    if (dv_val0.size() >= nd + 4 && ack_cyc0.size() > na && req_cyc0.size() >= nr + 4 &&
        mbits0.size() >= nb + 32) begin
      check("stream_span", 32'(dv_cyc0[nd + 3] - ack_cyc0[na]), 32'd64);
      for (int i = 0; i < 4; i++) begin
        check("stream_do", 32'(dv_val0[nd + i]), 32'(words[i]));
        check("stream_req_lead", 32'(dv_cyc0[nd + i] - req_cyc0[nr + i]), 32'd4);
        got = 8'h00;
        for (int j = 0; j < 8; j++) got = {got[6:0], mbits0[nb + 8 * i + j]};
        check("stream_mosi", 32'(got), 32'(words[i]));
      end
    end

    // Random loopback words.
    for (int i = 0; i < 4; i++) begin
      rw = 8'($urandom);
      word0(rw, rw, "rand_loop");
    end

    // MISO tied low, then high.
    miso_mode0 = 2;
    word0(8'($urandom), 8'h00, "miso_zero");
    miso_mode0 = 1;
    word0(8'($urandom), 8'hFF, "miso_one");

    // Reset during bit 3.
    miso_mode0 = 0;
    nd = dv_val0.size();
    rn = rise_n0;
    di0 = 8'h3C;
    wren0 = 1'b1;
    step();
    wren0 = 1'b0;
    k = 0;
    while (rise_n0 < rn + 4 && k < 100) begin step(); k++; end
    check("midrst_reached_bit3", 32'(rise_n0 - rn), 32'd4);
    rst0 = 1'b1;
    #1;
    check("midrst_ssel", 32'(ssel0), 32'd1);
    check("midrst_sck", 32'(sck0), 32'd0);
    check("midrst_mosi", 32'(mosi0), 32'd0);
    check("midrst_req", 32'(req0), 32'd0);
    check("midrst_ack", 32'(ack0), 32'd0);
    check("midrst_dv", 32'(dv0), 32'd0);
    check("midrst_do", 32'(do0), 32'd0);
    step();
    step();
    rst0 = 1'b0;
    step();
    check("midrst_req_back", 32'(req0), 32'd1);
    for (int i = 0; i < 20; i++) step();
    check("midrst_no_dv", 32'(dv_val0.size()), 32'(nd));
    word0(8'hA5, 8'hA5, "after_rst");

    // CPHA=1, CLK_DIV=3 instance.
    word1(8'hA5, "cpha1_a5");
    for (int i = 0; i < 3; i++) word1(8'($urandom), "cpha1_rand");
    for (int i = 0; i < 4; i++) step();
    check("cpha1_mosi_only_on_rise", 32'(bad_mchg1), 32'd0);
    check("cpha1_ssel_end", 32'(ssel1), 32'd1);
    check("idle_mosi_zero0", 32'(idle_mosi0), 32'd0);
    check("idle_mosi_zero1", 32'(idle_mosi1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
